// File: rtl/sop_sweep_checker.sv
// Sweeps all eight {A,B,C} vectors through an external SOP circuit, waits a
// settle time per vector, samples Y and scores it against an expected truth table.
module sop_sweep_checker #(
  parameter int unsigned SETTLE = 4,
  parameter logic [7:0]  EXPECT = 8'hE0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] abc,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_q,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] abc_q, abc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tbl_q, tbl_d;
  logic [3:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state and datapath updates for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abc_d   = abc_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 3'd0;
          abc_d   = 3'd0;
          tbl_d   = 8'h00;
          err_d   = 4'd0;
          pass_d  = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        tbl_d[idx_q] = y;
        if (y != EXPECT[idx_q]) begin
          err_d = err_q + 4'd1;
        end else begin
          err_d = err_q;
        end
        if (idx_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          abc_d   = idx_q + 3'd1;
          cnt_d   = CNT_INIT;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        // err_q already holds the idx=7 compare here.
        pass_d  = (err_q == 4'd0);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      abc_q   <= 3'd0;
      cnt_q   <= 4'd0;
      tbl_q   <= 8'h00;
      err_q   <= 4'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign abc     = abc_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign table_q = tbl_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_sop_sweep_checker.sv
// Bench for sop_sweep_checker: two instances (SETTLE=4 and SETTLE=1) driven by a
// truth-table model of the circuit under test, checked cycle by cycle.
module tb_sop_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       st;
  logic       sel;
  logic [7:0] ytab;

  logic       start0, start1, y0, y1;
  logic [2:0] abc0, abc1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] tbl0, tbl1;
  logic [3:0] err0, err1;

  logic [2:0] o_abc;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_tbl;
  logic [3:0] o_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start0 = st & ~sel;
  assign start1 = st & sel;
  assign y0     = ytab[abc0];
  assign y1     = ytab[abc1];

  assign o_abc  = sel ? abc1  : abc0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_pass = sel ? pass1 : pass0;
  assign o_tbl  = sel ? tbl1  : tbl0;
  assign o_err  = sel ? err1  : err0;

  sop_sweep_checker #(.SETTLE(4), .EXPECT(8'hE0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abc(abc0), .y(y0), .busy(busy0),
    .done(done0), .pass(pass0), .table_q(tbl0), .err_cnt(err0)
  );

  sop_sweep_checker #(.SETTLE(1), .EXPECT(8'hE0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abc(abc1), .y(y1), .busy(busy1),
    .done(done1), .pass(pass1), .table_q(tbl1), .err_cnt(err1)
  );

  // Truth table of Y = ABC + AB + AC evaluated straight from the equation.
  function automatic logic [7:0] golden();
    logic [7:0] g;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v    = i[2:0];
      g[i] = (v[2] & v[1] & v[0]) | (v[2] & v[1]) | (v[2] & v[0]);
    end
    return g;
  endfunction

  task automatic test_reset();
    rst = 1'b1; st = 1'b0; sel = 1'b0; ytab = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({o_abc, o_busy, o_done, o_pass, o_tbl, o_err} !== 18'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got=%h exp=0", s,
                 {o_abc, o_busy, o_done, o_pass, o_tbl, o_err});
      end
    end
    sel = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // One sweep on the selected instance; optionally pulses start mid-sweep.
  task automatic run_sweep(input bit s, input logic [7:0] tab, input bit glitch);
    int         sp, dc, gc;
    logic [2:0] ea;
    logic [3:0] eerr;
    sp   = s ? 2 : 5;
    dc   = 8 * sp + 1;
    eerr = 4'($countones(tab ^ 8'hE0));
    gc   = glitch ? int'($urandom_range(dc - 1, 2)) : 0;
    sel  = s; ytab = tab;
    @(posedge clk); #1 st = 1'b1;
    @(posedge clk); #1 st = 1'b0;
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      ea = (c >= dc) ? 3'd7 : 3'((c - 1) / sp);
      checks++;
      if (o_done !== (c == dc)) begin
        errors++;
        $display("FAIL done s%0d cyc=%0d got=%b exp=%b", s, c, o_done, c == dc);
      end
      checks++;
      if (o_busy !== (c <= dc)) begin
        errors++;
        $display("FAIL busy s%0d cyc=%0d got=%b exp=%b", s, c, o_busy, c <= dc);
      end
      checks++;
      if (o_abc !== ea) begin
        errors++;
        $display("FAIL abc s%0d cyc=%0d got=%0d exp=%0d", s, c, o_abc, ea);
      end
      checks++;
      if (o_pass !== ((c > dc) && (eerr == 4'd0))) begin
        errors++;
        $display("FAIL pass s%0d cyc=%0d got=%b exp=%b", s, c, o_pass,
                 (c > dc) && (eerr == 4'd0));
      end
      if (c == dc + 1) begin
        checks++;
        if (o_tbl !== tab) begin
          errors++;
          $display("FAIL table s%0d got=%h exp=%h", s, o_tbl, tab);
        end
        checks++;
        if (o_err !== eerr) begin
          errors++;
          $display("FAIL err_cnt s%0d got=%0d exp=%0d", s, o_err, eerr);
        end
      end
      st = (c == gc);
    end
    st = 1'b0;
  endtask

  task automatic test_golden();
    run_sweep(1'b0, golden(), 1'b0);
    run_sweep(1'b1, golden(), 1'b0);
  endtask

  task automatic test_tied();
    run_sweep(1'b0, 8'h00, 1'b0);
    run_sweep(1'b0, 8'hFF, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_sweep(1'($urandom_range(1, 0)), 8'($urandom), 1'b1);
    end
  endtask

  task automatic test_mid_reset();
    sel = 1'b0; ytab = golden();
    @(posedge clk); #1 st = 1'b1;
    @(posedge clk); #1 st = 1'b0;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_abc, o_busy, o_done, o_pass, o_tbl, o_err} !== 18'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0", {o_abc, o_busy, o_done, o_pass, o_tbl, o_err});
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle cyc=%0d got=%b%b exp=00", c, o_done, o_busy);
      end
    end
    run_sweep(1'b0, golden(), 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; ytab = golden();
    @(posedge clk); #1 st = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 126; c++) begin
      @(negedge clk);
      checks++;
      if (o_done !== (c % 42 == 41)) begin
        errors++;
        $display("FAIL b2b_done cyc=%0d got=%b exp=%b", c, o_done, c % 42 == 41);
      end
      checks++;
      if (o_pass !== (c % 42 == 0)) begin
        errors++;
        $display("FAIL b2b_pass cyc=%0d got=%b exp=%b", c, o_pass, c % 42 == 0);
      end
      checks++;
      if (o_busy !== (c % 42 != 0)) begin
        errors++;
        $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", c, o_busy, c % 42 != 0);
      end
      if (c == 125) st = 1'b0;
    end
    st = 1'b0;
  endtask

  initial begin
    test_reset();
    test_golden();
    test_tied();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sop_sweep_checker.md
# sop_sweep_checker

Sequential stimulus-and-check stage wrapped around the three-input SOP equation circuit (Y = ABC + AB + AC, which reduces to A·(B+C)). On a start request it drives all eight {A,B,C} combinations into the circuit in ascending order. For each combination it waits a programmable settle time, samples Y, and builds the observed truth table. It compares each sample against an expected table and reports the mismatch count, a pass flag and a done pulse.

## Interface
- SETTLE, 4: cycles abc is held before Y is sampled; legal range 1..15.
- EXPECT, 8'hE0: expected truth table; bit i is the required Y for {A,B,C} = i. 8'hE0 encodes A·(B+C).

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous, active-high; clears every register.
- start  in  1  sweep request; sampled only in IDLE.
- abc  out  3  drives the circuit: abc[2]=A, abc[1]=B, abc[0]=C. Registered.
- y  in  1  circuit output Y; treated as settled after SETTLE cycles.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  high when the last completed sweep had err_cnt = 0; held until the next accepted start.
- table_q  out  8  observed truth table; bit i is the Y sampled for abc = i.
- err_cnt  out  4  number of mismatches in the current or last sweep (0..8).

## Operation
- State machine states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start = 1: idx←0, abc←0, table_q←0, err_cnt←0, pass←0, cnt←SETTLE−1; go to SETTLE.
  - Otherwise hold all outputs.
- SETTLE:
  - If cnt = 0, go to SAMPLE.
  - Otherwise cnt←cnt−1.
  - abc stays stable throughout.
- SAMPLE:
  - table_q[idx]←y.
  - If y ≠ EXPECT[idx], err_cnt←err_cnt+1.
  - If idx = 7, go to DONE.
  - Otherwise idx←idx+1, abc←idx+1, cnt←SETTLE−1; go to SETTLE.
- DONE:
  - done=1 for exactly this cycle.
  - pass←(final err_cnt = 0), using the count that includes the idx=7 compare.
  - Go to IDLE.
- Width rules:
  - idx and abc are 3 bits; there is no wrap-around because the sweep stops at idx=7.
  - err_cnt is 4 bits and never exceeds 8, so it needs no saturation.
- start asserted during SETTLE, SAMPLE or DONE is ignored; there is no queuing.
- table_q, err_cnt, pass and abc retain their last-sweep values in IDLE.
- Reset (asynchronous, any state, including mid-sweep):
  - state←IDLE, abc←0, table_q←0, err_cnt←0, pass←0, done←0, busy←0, idx←0, cnt←0.
  - The sweep is abandoned with no done pulse.

## Timing
- Reset values: every output is 0.
- Call the edge at which start is sampled high in IDLE edge 0.
- busy is high from cycle 1 through the DONE cycle.
- abc changes only on the edge that enters SETTLE:
  - vector k is driven from cycle k·(SETTLE+1)+1;
  - y is sampled at the end of cycle (k+1)·(SETTLE+1).
- Each vector takes SETTLE+1 cycles: SETTLE cycles in SETTLE, 1 in SAMPLE.
- done is high in cycle 8·(SETTLE+1)+1, which is cycle 41 for SETTLE=4.
- pass is valid from the cycle after done.
- IDLE lasts at least one cycle between sweeps. With start held high, sweeps repeat every 8·(SETTLE+1)+2 cycles (42 for SETTLE=4).
- The clock period × SETTLE must exceed the worst-case gate-path delay of the circuit (3 gate delays).

## Test plan
- Golden circuit connected, SETTLE=4, single start pulse -> done high in cycle 41 only; table_q=8'hE0, err_cnt=0, pass=1; abc steps 0..7 at 5-cycle intervals.
- y tied to 0 -> table_q=8'h00, err_cnt=3, pass=0.
- y tied to 1 -> table_q=8'hFF, err_cnt=5, pass=0.
- rst pulsed at cycle 15 of a sweep -> all outputs 0 immediately (asynchronous) and no done pulse; a later start runs a full sweep giving table_q=8'hE0, pass=1.
- start held high continuously with the golden circuit -> done pulses at cycles 41, 83 and 125; pass stays 0 between each start and its done, then returns to 1; start asserted during busy is ignored.
- SETTLE=1 parameter override with the golden circuit -> done in cycle 17; table_q=8'hE0, pass=1.
